// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS-style MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO.
// One multiplier/quotient bit per cycle over a shared 2*DWL-bit working accumulator.
module mult_div_unit #(
    parameter int DWL = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [1:0]     op_i,
    input  logic [DWL-1:0] srca_i,
    input  logic [DWL-1:0] srcb_i,
    input  logic           hiwe_i,
    input  logic           lowe_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [DWL-1:0] hi_o,
    output logic [DWL-1:0] lo_o,
    output logic           divz_o
);
    localparam int CW = $clog2(DWL) + 1;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           state_q;
    logic             div_q, nq_q, nr_q, nowr_q, done_q, divz_q;
    logic [CW-1:0]    cnt_q;
    logic [DWL-1:0]   m_q, hi_q, lo_q, hi_d, lo_d, a_mag, b_mag;
    logic [2*DWL-1:0] acc_q, acc_d, prod;
    logic [DWL:0]     sum, sh, diff;
    logic             zdiv;
    always_comb begin
        a_mag = (op_i[0] && srca_i[DWL-1]) ? -srca_i : srca_i;
        b_mag = (op_i[0] && srcb_i[DWL-1]) ? -srcb_i : srcb_i;
        zdiv  = op_i[1] && (srcb_i == '0);
        sum   = {1'b0, acc_q[2*DWL-1:DWL]} + (acc_q[0] ? {1'b0, m_q} : '0);
        sh    = {acc_q[2*DWL-1:DWL], acc_q[DWL-1]};
        diff  = sh - {1'b0, m_q};
        // Divide: upper half is the partial remainder, lower half shifts in quotient bits.
        acc_d = div_q ? (diff[DWL] ? {sh[DWL-1:0], acc_q[DWL-2:0], 1'b0}
                                   : {diff[DWL-1:0], acc_q[DWL-2:0], 1'b1})
                      : {sum, acc_q[DWL-1:1]};
        prod  = nq_q ? -acc_q : acc_q;
        hi_d  = div_q ? (nr_q ? -acc_q[2*DWL-1:DWL] : acc_q[2*DWL-1:DWL]) : prod[2*DWL-1:DWL];
        lo_d  = div_q ? (nq_q ? -acc_q[DWL-1:0] : acc_q[DWL-1:0]) : prod[DWL-1:0];
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= 1'b0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            nowr_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        div_q   <= op_i[1];
                        nq_q    <= op_i[0] && (srca_i[DWL-1] ^ srcb_i[DWL-1]);
                        nr_q    <= op_i[0] && srca_i[DWL-1];
                        nowr_q  <= zdiv;
                        divz_q  <= zdiv;
                        cnt_q   <= '0;
                        m_q     <= op_i[1] ? b_mag : a_mag;
                        acc_q   <= {{DWL{1'b0}}, op_i[1] ? a_mag : b_mag};
                        state_q <= zdiv ? FIX : RUN;
                    end else begin
                        if (hiwe_i) hi_q <= srca_i;
                        if (lowe_i) lo_q <= srca_i;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DWL - 1)) state_q <= FIX;
                end
                FIX: begin
                    if (!nowr_q) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign divz_o = divz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scenario tasks with a scoreboard of expected HI/LO/DIVZ checked at each DONE.
module tb_mult_div_unit;
    logic        clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, hiwe_i = 1'b0, lowe_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [31:0] srca_i = '0, srcb_i = '0;
    logic        busy_o, done_o, divz_o;
    logic [31:0] hi_o, lo_o;
    typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz;} exp_t;
    exp_t        sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int          checks = 0, failures = 0;

    mult_div_unit #(.DWL(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .srca_i(srca_i), .srcb_i(srcb_i), .hiwe_i(hiwe_i), .lowe_i(lowe_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o), .divz_o(divz_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference arithmetic built on the simulator's 64-bit integer operators.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = 1'b0;
        if (op == 2'd0) begin
            p = {32'h0, a} * {32'h0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (op == 2'd1) begin
            p = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'h0) begin
            e.dz = 1'b1;
        end else if (op == 2'd2) begin
            e.lo = a / b;
            e.hi = a % b;
        end else begin
            p = sa / sb;
            e.lo = p[31:0];
            p = sa % sb;
            e.hi = p[31:0];
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start_i = 1'b1;
        op_i = op;
        srca_i = a;
        srcb_i = b;
        e = model(op, a, b);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        srca_i = $urandom;
        srcb_i = $urandom;
        @(negedge clk_i);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_o && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({hi_o, lo_o, busy_o, done_o, divz_o} !== 67'h0) begin
            failures++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b divz=%b required all zero", hi_o, lo_o, busy_o, done_o, divz_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_multu_timing;
        int   bad = 0;
        exp_t e;
        issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int c = 1; c <= 33; c++) begin
            if (busy_o !== 1'b1 || done_o !== 1'b0) bad++;
            @(negedge clk_i);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL multu_busy: %0d bad cycles in 1..33, required 0", bad);
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL multu_done_cycle34: done=%b busy=%b required done=1 busy=0", done_o, busy_o);
        end
        e = sb.pop_front();
        checks++;
        if (hi_o !== 32'hFFFFFFFE || lo_o !== 32'h00000001 || hi_o !== e.hi || lo_o !== e.lo) begin
            failures++;
            $display("FAIL multu_result: hi=%h lo=%h required hi=fffffffe lo=00000001", hi_o, lo_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL multu_done_width: done=%b required 0", done_o);
        end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        exp_t e;
        issue(2'd1, 32'hFFFFFFFD, 32'd7);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != 34 || hi_o !== e.hi || lo_o !== e.lo || lo_o !== 32'hFFFFFFEB) begin
            failures++;
            $display("FAIL mult_neg: cycle=%0d hi=%h lo=%h required cycle=34 hi=%h lo=%h", cyc, hi_o, lo_o, e.hi, e.lo);
        end
        issue(2'd2, 32'd100, 32'd7);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != 34 || hi_o !== 32'd2 || lo_o !== 32'd14 || lo_o !== e.lo) begin
            failures++;
            $display("FAIL divu_b2b: cycle=%0d hi=%h lo=%h required cycle=34 hi=2 lo=14", cyc, hi_o, lo_o);
        end
    endtask

    task automatic test_div_signed;
        int   cyc;
        exp_t e;
        issue(2'd3, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD || divz_o !== 1'b0 || lo_o !== e.lo) begin
            failures++;
            $display("FAIL div_neg: hi=%h lo=%h divz=%b required hi=ffffffff lo=fffffffd divz=0", hi_o, lo_o, divz_o);
        end
        issue(2'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h80000000 || hi_o !== e.hi || lo_o !== e.lo) begin
            failures++;
            $display("FAIL div_overflow: hi=%h lo=%h required hi=0 lo=80000000", hi_o, lo_o);
        end
    endtask

    task automatic test_mthi_div0;
        int   cyc;
        exp_t e;
        hiwe_i = 1'b1; lowe_i = 1'b1; srca_i = 32'hABCD0123;
        @(negedge clk_i);
        checks++;
        if (hi_o !== 32'hABCD0123 || lo_o !== 32'hABCD0123) begin
            failures++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h required abcd0123", hi_o, lo_o);
        end
        lowe_i = 1'b0; srca_i = 32'h11;
        @(negedge clk_i);
        hiwe_i = 1'b0; lowe_i = 1'b1; srca_i = 32'h22;
        @(negedge clk_i);
        lowe_i = 1'b0;
        m_hi = 32'h11; m_lo = 32'h22;
        checks++;
        if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
            failures++;
            $display("FAIL preload: hi=%h lo=%h required hi=11 lo=22", hi_o, lo_o);
        end
        issue(2'd2, 32'h1234, 32'h0);
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL div0_cycle1: busy=%b done=%b required busy=1 done=0", busy_o, done_o);
        end
        @(negedge clk_i);
        e = sb.pop_front();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || divz_o !== e.dz || hi_o !== e.hi || lo_o !== e.lo) begin
            failures++;
            $display("FAIL div0_cycle2: done=%b busy=%b divz=%b hi=%h lo=%h required 1 0 1 11 22", done_o, busy_o, divz_o, hi_o, lo_o);
        end
        hiwe_i = 1'b1;
        issue(2'd0, 32'd3, 32'd4);
        hiwe_i = 1'b0;
        checks++;
        if (divz_o !== 1'b0 || hi_o !== 32'h11) begin
            failures++;
            $display("FAIL start_clears_divz_drops_mthi: divz=%b hi=%h required divz=0 hi=11", divz_o, hi_o);
        end
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (hi_o !== e.hi || lo_o !== 32'd12 || divz_o !== 1'b0) begin
            failures++;
            $display("FAIL multu_after_div0: hi=%h lo=%h divz=%b required hi=0 lo=c divz=0", hi_o, lo_o, divz_o);
        end
    endtask

    task automatic test_ignore_busy;
        int   cyc, extra = 0;
        exp_t e;
        logic [31:0] old_hi;
        old_hi = hi_o;
        issue(2'd0, 32'd5, 32'd6);
        repeat (4) @(negedge clk_i);
        start_i = 1'b1; op_i = 2'd3; hiwe_i = 1'b1; srca_i = 32'hDEAD; srcb_i = 32'h0;
        @(posedge clk_i);
        #1;
        start_i = 1'b0; hiwe_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (hi_o !== old_hi || divz_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_side_effect: hi=%h divz=%b required hi=%h divz=0", hi_o, divz_o, old_hi);
        end
        cyc = 6;
        while (!done_o && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (cyc != 34 || hi_o !== 32'h0 || lo_o !== 32'd30 || lo_o !== e.lo) begin
            failures++;
            $display("FAIL busy_ignore_result: cycle=%0d hi=%h lo=%h required cycle=34 hi=0 lo=1e", cyc, hi_o, lo_o);
        end
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL busy_ignore_single_done: %0d extra DONE pulses required 0", extra);
        end
    endtask

    task automatic test_random;
        int          cyc;
        exp_t        e;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i % 4 == 1) a = -a;
            issue(2'(i % 4), a, b);
            wait_done(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc != 34 || hi_o !== e.hi || lo_o !== e.lo || divz_o !== e.dz) begin
                failures++;
                $display("FAIL random_%0d: op=%0d a=%h b=%h cycle=%0d hi=%h lo=%h required hi=%h lo=%h", i, i % 4, a, b, cyc, hi_o, lo_o, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_reset_abort;
        int extra = 0;
        issue(2'd1, 32'hFFFFFF00, 32'h1234);
        repeat (9) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        void'(sb.pop_front());
        checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_state: hi=%h lo=%h busy=%b done=%b required all zero", hi_o, lo_o, busy_o, done_o);
        end
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL reset_abort_done: %0d DONE pulses required 0", extra);
        end
    endtask

    initial begin
        test_reset;
        test_multu_timing;
        test_back_to_back;
        test_div_signed;
        test_mthi_div0;
        test_ignore_busy;
        test_random;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
